// File: rtl/ram_bus_arbiter_if.sv
// ============================================================================
// ram_bus_arbiter_if
// Bundles the CPU, loader and RAM-macro signals around the RAM arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

interface ram_bus_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          boot;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Requesters and RAM macro: drive requests and read data, observe grants.
  modport master (
    output boot,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

  // Arbiter view.
  modport slave (
    input  boot,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/ram_bus_arbiter.sv
// ============================================================================
// ram_bus_arbiter
// Shares one single-port RAM between the CPU and the boot loader.
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_bus_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int HOLD_MAX = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  ram_bus_arbiter_if.slave    bus
);

  localparam int HCW = $clog2(HOLD_MAX + 1);
  localparam logic [HCW-1:0] c_HOLD_LAST = HCW'(HOLD_MAX - 1);
  localparam logic [HCW-1:0] c_HOLD_SAT  = HCW'(HOLD_MAX);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_FAIR = 2'd2
  } state_t;

  state_t         r_state;
  logic [HCW-1:0] r_hold_cnt;
  logic           r_cpu_rvalid;
  logic           r_ld_rvalid;
  logic [DW-1:0]  r_cpu_rdata;
  logic [DW-1:0]  r_ld_rdata;

  logic           w_cpu_gnt;
  logic           w_ld_gnt;
  logic           w_to_fair;

  // Grant decode; nothing is granted while reset is held low.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ld_gnt  = 1'b0;
    if (rst) begin
      case (r_state)
        S_BOOT: w_ld_gnt = bus.ld_req;
        S_RUN: begin
          w_cpu_gnt = bus.cpu_req;
          w_ld_gnt  = bus.ld_req & ~bus.cpu_req;
        end
        S_FAIR: begin
          w_ld_gnt  = bus.ld_req;
          w_cpu_gnt = bus.cpu_req & ~bus.ld_req;
        end
        default: begin
          w_cpu_gnt = 1'b0;
          w_ld_gnt  = 1'b0;
        end
      endcase
    end
  end

  assign w_to_fair = (r_state == S_RUN) & w_cpu_gnt & bus.ld_req &
                     (r_hold_cnt == c_HOLD_LAST);

  always_comb begin
    bus.cpu_gnt   = w_cpu_gnt;
    bus.ld_gnt    = w_ld_gnt;
    bus.ram_en    = w_cpu_gnt | w_ld_gnt;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (w_cpu_gnt) begin
      bus.ram_we    = bus.cpu_we;
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_wdata = bus.cpu_wdata;
    end else if (w_ld_gnt) begin
      bus.ram_we    = bus.ld_we;
      bus.ram_addr  = bus.ld_addr;
      bus.ram_wdata = bus.ld_wdata;
    end
  end

  // Read data passes straight through in the valid cycle and is held afterwards.
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.ld_rvalid  = r_ld_rvalid;
  assign bus.cpu_rdata  = r_cpu_rvalid ? bus.ram_rdata : r_cpu_rdata;
  assign bus.ld_rdata   = r_ld_rvalid  ? bus.ram_rdata : r_ld_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_BOOT;
      r_hold_cnt   <= '0;
      r_cpu_rvalid <= 1'b0;
      r_ld_rvalid  <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ld_rdata   <= '0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt & ~bus.cpu_we;
      r_ld_rvalid  <= w_ld_gnt & ~bus.ld_we;
      if (r_cpu_rvalid) r_cpu_rdata <= bus.ram_rdata;
      if (r_ld_rvalid)  r_ld_rdata  <= bus.ram_rdata;

      if (bus.boot) begin
        r_state <= S_BOOT;
      end else begin
        case (r_state)
          S_BOOT:  r_state <= S_RUN;
          S_RUN:   if (w_to_fair) r_state <= S_FAIR;
          S_FAIR:  r_state <= S_RUN;
          default: r_state <= S_BOOT;
        endcase
      end

      // Counts CPU wins over a waiting loader; any loader service or idle loader resets it.
      if (bus.boot || w_to_fair || w_ld_gnt || !bus.ld_req) begin
        r_hold_cnt <= '0;
      end else if (w_cpu_gnt && (r_hold_cnt != c_HOLD_SAT)) begin
        r_hold_cnt <= r_hold_cnt + HCW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_arbiter.sv
// ============================================================================
// tb_ram_bus_arbiter
// Directed bench with a per-cycle reference model of the RAM arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_bus_arbiter;

  localparam int AW       = 4;
  localparam int DW       = 8;
  localparam int HOLD_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ram_bus_arbiter_if #(.AW(AW), .DW(DW)) bus();

  ram_bus_arbiter #(.AW(AW), .DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous-read RAM macro
  logic [DW-1:0] mem [16] = '{default: '0};
  logic [DW-1:0] ram_q = '0;
  assign bus.ram_rdata = ram_q;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            ram_q <= mem[bus.ram_addr];
    end
  end

  // Reference model: who may use the RAM, a streak of CPU wins over a
  // waiting loader, and the expected read returns.
  logic [DW-1:0] m_mem [16] = '{default: '0};
  bit            m_on     = 1'b0;
  bit            m_boot   = 1'b1;
  int            m_streak = 0;
  bit            m_pc     = 1'b0;
  bit            m_pl     = 1'b0;
  logic [DW-1:0] m_cd     = '0;
  logic [DW-1:0] m_ld     = '0;

  function automatic void exp_gnt(output bit cg, output bit lg);
    cg = 1'b0;
    lg = 1'b0;
    if (rst) begin
      if (m_boot) begin
        lg = bus.ld_req;
      end else if (m_streak >= HOLD_MAX) begin
        lg = bus.ld_req;
        cg = bus.cpu_req && !bus.ld_req;
      end else begin
        cg = bus.cpu_req;
        lg = bus.ld_req && !bus.cpu_req;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit cg, lg;
    exp_gnt(cg, lg);
    if (!rst) begin
      m_boot   = 1'b1;
      m_streak = 0;
      m_pc     = 1'b0;
      m_pl     = 1'b0;
    end else begin
      m_pc = cg && !bus.cpu_we;
      if (m_pc) m_cd = m_mem[bus.cpu_addr];
      m_pl = lg && !bus.ld_we;
      if (m_pl) m_ld = m_mem[bus.ld_addr];
      if (cg && bus.cpu_we) m_mem[bus.cpu_addr] = bus.cpu_wdata;
      if (lg && bus.ld_we)  m_mem[bus.ld_addr]  = bus.ld_wdata;
      if (bus.boot || m_streak >= HOLD_MAX) m_streak = 0;
      else if (cg && bus.ld_req)            m_streak = m_streak + 1;
      else                                  m_streak = 0;
      m_boot = bus.boot;
    end
    m_on = 1'b1;
  end

  always @(negedge clk) begin
    bit cg, lg;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    if (m_on) begin
      exp_gnt(cg, lg);
      e_we   = cg ? bus.cpu_we    : (lg ? bus.ld_we    : 1'b0);
      e_addr = cg ? bus.cpu_addr  : (lg ? bus.ld_addr  : '0);
      e_wd   = cg ? bus.cpu_wdata : (lg ? bus.ld_wdata : '0);
      chk("m_cpu_gnt",    32'(bus.cpu_gnt),    32'(cg));
      chk("m_ld_gnt",     32'(bus.ld_gnt),     32'(lg));
      chk("m_ram_en",     32'(bus.ram_en),     32'(cg | lg));
      chk("m_ram_we",     32'(bus.ram_we),     32'(e_we));
      chk("m_ram_addr",   32'(bus.ram_addr),   32'(e_addr));
      chk("m_ram_wdata",  32'(bus.ram_wdata),  32'(e_wd));
      chk("m_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_pc));
      chk("m_ld_rvalid",  32'(bus.ld_rvalid),  32'(m_pl));
      if (m_pc) chk("m_cpu_rdata", 32'(bus.cpu_rdata), 32'(m_cd));
      if (m_pl) chk("m_ld_rdata",  32'(bus.ld_rdata),  32'(m_ld));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] pat_ld;

  initial begin
    bus.boot      = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.ld_req    = 1'b1;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_wdata  = '0;

    // Reset held with both requests active
    repeat (2) begin
      @(negedge clk);
      chk("rst_cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
      chk("rst_ld_gnt",     32'(bus.ld_gnt),     32'd0);
      chk("rst_ram_en",     32'(bus.ram_en),     32'd0);
      chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      nxt();
    end

    // Boot load of all 16 locations while the CPU keeps requesting
    rst       = 1'b1;
    bus.ld_we = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus.ld_addr  = 4'(a);
      bus.ld_wdata = 8'(8'hA0 + a);
      @(negedge clk);
      chk("boot_ld_gnt",   32'(bus.ld_gnt),   32'd1);
      chk("boot_cpu_gnt",  32'(bus.cpu_gnt),  32'd0);
      chk("boot_ram_we",   32'(bus.ram_we),   32'd1);
      chk("boot_ram_addr", 32'(bus.ram_addr), 32'(a));
      nxt();
    end

    // Leave boot, CPU reads address 5
    bus.boot    = 1'b0;
    bus.ld_req  = 1'b0;
    bus.ld_we   = 1'b0;
    bus.cpu_req = 1'b0;
    nxt();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 4'h5;
    @(negedge clk);
    chk("rd5_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    nxt();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("rd5_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("rd5_cpu_rdata",  32'(bus.cpu_rdata),  32'h0A5);
    chk("rd5_ld_rvalid",  32'(bus.ld_rvalid),  32'd0);
    nxt();

    // CPU write then read-back of address 3
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 4'h3;
    bus.cpu_wdata = 8'h5A;
    nxt();
    bus.cpu_we = 1'b0;
    @(negedge clk);
    chk("wr3_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    nxt();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("rd3_cpu_rdata", 32'(bus.cpu_rdata), 32'h05A);
    nxt();

    // Contention: four CPU grants, then the loader
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 4'h1;
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 4'h2;
    pat_ld = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("pat_cpu_gnt", 32'(bus.cpu_gnt), 32'(!pat_ld[i]));
      chk("pat_ld_gnt",  32'(bus.ld_gnt),  32'(pat_ld[i]));
      nxt();
    end

    // CPU read in N, loader read in N+1 during the fair slot
    for (int i = 0; i < 4; i++) begin
      bus.cpu_addr = (i == 3) ? 4'h7 : 4'h3;
      nxt();
    end
    bus.cpu_req = 1'b0;
    bus.ld_addr = 4'h9;
    @(negedge clk);
    chk("b2b_ld_gnt",     32'(bus.ld_gnt),     32'd1);
    chk("b2b_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("b2b_cpu_rdata",  32'(bus.cpu_rdata),  32'h0A7);
    chk("b2b_ld_rvalid0", 32'(bus.ld_rvalid),  32'd0);
    nxt();
    bus.ld_req = 1'b0;
    @(negedge clk);
    chk("b2b_ld_rvalid",   32'(bus.ld_rvalid),  32'd1);
    chk("b2b_ld_rdata",    32'(bus.ld_rdata),   32'h0A9);
    chk("b2b_cpu_rvalid0", 32'(bus.cpu_rvalid), 32'd0);
    nxt();

    // Reset lands on the edge that would have returned a CPU read
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 4'h2;
    @(negedge clk);
    chk("mid_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    #2 rst = 1'b0;
    nxt();
    @(negedge clk);
    chk("mid_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("mid_cpu_gnt_rst", 32'(bus.cpu_gnt), 32'd0);
    nxt();
    rst = 1'b1;
    @(negedge clk);
    chk("post_boot_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    nxt();
    @(negedge clk);
    chk("post_run_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    nxt();
    bus.ld_req  = 1'b1;
    bus.ld_addr = 4'h4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_ld_gnt", 32'(bus.ld_gnt), 32'(i == 4));
      nxt();
    end

    bus.cpu_req = 1'b0;
    bus.ld_req  = 1'b0;
    nxt();
    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
